// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped byte I/O port: widths, port addresses
// and status-register bit positions.
package io_pkg;

  localparam int IO_DATA_W   = 8;
  localparam int IO_ADDR_W   = 8;
  localparam int IO_TX_DEPTH = 4;

  localparam logic [IO_ADDR_W-1:0] IO_DATA_ADDR   = 8'hFF;
  localparam logic [IO_ADDR_W-1:0] IO_STATUS_ADDR = IO_DATA_ADDR - 8'd1;

  localparam int ST_TX_FULL = 0;
  localparam int ST_RX_FULL = 1;
  localparam int ST_TX_OVF  = 2;

  // Status byte as seen by the processor; unused upper bits read as zero.
  function automatic logic [IO_DATA_W-1:0] pack_status(input logic tx_ovf,
                                                       input logic rx_full,
                                                       input logic tx_full);
    logic [IO_DATA_W-1:0] s;
    s             = '0;
    s[ST_TX_FULL] = tx_full;
    s[ST_RX_FULL] = rx_full;
    s[ST_TX_OVF]  = tx_ovf;
    return s;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; pushes while full and
// pops while empty are ignored.
module io_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is reset too, so the fall-through output reads zero out of
  // reset instead of X; state updates use non-blocking assignments throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// Byte I/O peripheral: processor stores to IO_ADDR feed a TX FIFO, loads pop a
// 1-entry RX holding register. Define IO_PORT_STATUS_EN for the status port and tx_ovf flag.
module io_port_controller
  import io_pkg::*;
#(
  parameter int                   DATA_W   = IO_DATA_W,
  parameter int                   TX_DEPTH = IO_TX_DEPTH,
  parameter logic [IO_ADDR_W-1:0] IO_ADDR  = IO_DATA_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IO_ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  output logic [DATA_W-1:0]    cpu_rdata,
  output logic [DATA_W-1:0]    ext_tx_data,
  output logic                 ext_tx_valid,
  input  logic                 ext_tx_ready,
  input  logic [DATA_W-1:0]    ext_rx_data,
  input  logic                 ext_rx_valid,
  output logic                 ext_rx_ready
);

  logic              data_sel;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;
  logic              rx_full;
  logic [DATA_W-1:0] rx_data;
  logic              rx_accept;
  logic              rx_pop;

  assign data_sel = (cpu_addr == IO_ADDR);

  // Full is sampled before any same-cycle pop, so a store to a full FIFO is lost.
  assign tx_push      = cpu_we && data_sel && !tx_full;
  assign ext_tx_valid = !tx_empty;
  assign tx_pop       = ext_tx_valid && ext_tx_ready;

  io_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (tx_push),
    .wdata (cpu_wdata),
    .pop   (tx_pop),
    .rdata (ext_tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign ext_rx_ready = !rx_full;
  assign rx_accept    = ext_rx_valid && ext_rx_ready;
  assign rx_pop       = cpu_re && data_sel && rx_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_full <= 1'b0;
      rx_data <= '0;
    end else if (rx_accept) begin
      rx_full <= 1'b1;
      rx_data <= ext_rx_data;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

`ifdef IO_PORT_STATUS_EN
  localparam logic [IO_ADDR_W-1:0] STATUS_ADDR = IO_ADDR - 8'd1;

  logic stat_sel;
  logic tx_ovf;
  logic ovf_set;
  logic ovf_clr;

  assign stat_sel = (cpu_addr == STATUS_ADDR);
  assign ovf_set  = cpu_we && data_sel && tx_full;
  assign ovf_clr  = cpu_re && stat_sel;

  // A new overflow in the same cycle as the clearing read stays visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       tx_ovf <= 1'b0;
    else if (ovf_set) tx_ovf <= 1'b1;
    else if (ovf_clr) tx_ovf <= 1'b0;
  end
`endif

  // NOTE: cpu_rdata gets a default before any condition so no latch is inferred.
  always_comb begin
    cpu_rdata = '0;
    if (data_sel && rx_full) cpu_rdata = rx_data;
`ifdef IO_PORT_STATUS_EN
    if (stat_sel) cpu_rdata = DATA_W'(pack_status(tx_ovf, rx_full, tx_full));
`endif
  end

endmodule

// File: tb/tb_io_port_controller.sv
// Self-checking bench for io_port_controller: directed scenarios plus a random
// run against a queue-based reference model.
module tb_io_port_controller;

`ifdef IO_PORT_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic       cpu_re;
  logic [7:0] cpu_rdata;
  logic [7:0] ext_tx_data;
  logic       ext_tx_valid;
  logic       ext_tx_ready;
  logic [7:0] ext_rx_data;
  logic       ext_rx_valid;
  logic       ext_rx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_rx_full;
  logic [7:0] m_rx_data;
  bit         m_ovf;

  io_port_controller dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_re       (cpu_re),
    .cpu_rdata    (cpu_rdata),
    .ext_tx_data  (ext_tx_data),
    .ext_tx_valid (ext_tx_valid),
    .ext_tx_ready (ext_tx_ready),
    .ext_rx_data  (ext_rx_data),
    .ext_rx_valid (ext_rx_valid),
    .ext_rx_ready (ext_rx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_addr     = 8'h00;
    cpu_wdata    = 8'h00;
    cpu_we       = 1'b0;
    cpu_re       = 1'b0;
    ext_tx_ready = 1'b0;
    ext_rx_data  = 8'h00;
    ext_rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    cpu_addr = 8'hFF;
    #3;
    n_checks++; if (ext_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", ext_tx_valid); end
    n_checks++; if (ext_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", ext_tx_data); end
    n_checks++; if (ext_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b expected 1", ext_rx_ready); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", cpu_rdata); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    cpu_addr = 8'hFE;
    #1;
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", cpu_rdata); end
    n_checks++; if (ext_tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_tx_valid: got %b expected 0", ext_tx_valid); end
    idle();
  endtask

  task automatic test_tx_order();
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    cpu_we = 1'b1; cpu_addr = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cpu_wdata = exp[i];
      #1;
      if (i == 0) begin
        n_checks++; if (ext_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_valid_before_store: got %b expected 0", ext_tx_valid); end
      end
      tick();
      if (i == 0) begin
        n_checks++; if (ext_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_valid_latency: got %b expected 1", ext_tx_valid); end
      end
    end
    cpu_we = 1'b0;
    ext_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ext_tx_valid !== 1'b1 || ext_tx_data !== exp[i]) begin n_fail++; $display("FAIL tx_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, ext_tx_valid, ext_tx_data, exp[i]); end
      tick();
    end
    n_checks++; if (ext_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got %b expected 0", ext_tx_valid); end
    idle();
  endtask

  task automatic test_overflow();
    cpu_we = 1'b1; cpu_addr = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      cpu_wdata = 8'hA0 + 8'(i);
      tick();
    end
    cpu_we = 1'b0;
    cpu_addr = 8'hFE; cpu_re = 1'b1;
    #1;
    n_checks++; if (cpu_rdata !== (STATUS_EN ? 8'h05 : 8'h00)) begin n_fail++; $display("FAIL ovf_status1: got %h expected %h", cpu_rdata, STATUS_EN ? 8'h05 : 8'h00); end
    tick();
    n_checks++; if (cpu_rdata !== (STATUS_EN ? 8'h01 : 8'h00)) begin n_fail++; $display("FAIL ovf_status2: got %h expected %h", cpu_rdata, STATUS_EN ? 8'h01 : 8'h00); end
    tick();
    idle();
    ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (ext_tx_valid !== 1'b1 || ext_tx_data !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, ext_tx_valid, ext_tx_data, 8'hA0 + 8'(i)); end
      tick();
    end
    n_checks++; if (ext_tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain_empty: got %b expected 0", ext_tx_valid); end
    idle();
  endtask

  task automatic test_rx();
    ext_rx_data = 8'hF0; ext_rx_valid = 1'b1;
    #1;
    n_checks++; if (ext_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_idle: got %b expected 1", ext_rx_ready); end
    tick();
    ext_rx_valid = 1'b0;
    cpu_addr = 8'hFE;
    #1;
    n_checks++; if (ext_rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_full: got %b expected 0", ext_rx_ready); end
    n_checks++; if (cpu_rdata !== (STATUS_EN ? 8'h02 : 8'h00)) begin n_fail++; $display("FAIL rx_status: got %h expected %h", cpu_rdata, STATUS_EN ? 8'h02 : 8'h00); end
    cpu_addr = 8'hFF; cpu_re = 1'b1;
    #1;
    n_checks++; if (cpu_rdata !== 8'hF0) begin n_fail++; $display("FAIL rx_load1: got %h expected f0", cpu_rdata); end
    tick();
    n_checks++; if (ext_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_after_pop: got %b expected 1", ext_rx_ready); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rx_load2: got %h expected 00", cpu_rdata); end
    tick();
    idle();
  endtask

  task automatic test_rx_backpressure();
    ext_rx_data = 8'h5A; ext_rx_valid = 1'b1;
    tick();
    ext_rx_data = 8'hAB;
    cpu_addr = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ext_rx_ready !== 1'b0 || cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL rx_hold[%0d]: got rdy=%b d=%h expected rdy=0 d=5a", i, ext_rx_ready, cpu_rdata); end
      tick();
    end
    cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
    n_checks++; if (ext_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_bp_ready: got %b expected 1", ext_rx_ready); end
    tick();
    ext_rx_valid = 1'b0;
    #1;
    n_checks++; if (ext_rx_ready !== 1'b0 || cpu_rdata !== 8'hAB) begin n_fail++; $display("FAIL rx_bp_next: got rdy=%b d=%h expected rdy=0 d=ab", ext_rx_ready, cpu_rdata); end
    cpu_re = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    cpu_we = 1'b1; cpu_addr = 8'hFF;
    for (int i = 0; i < 3; i++) begin cpu_wdata = 8'hC1 + 8'(i); tick(); end
    cpu_wdata = 8'hC4; ext_tx_ready = 1'b1;
    tick();
    cpu_we = 1'b0; ext_tx_ready = 1'b0;
    exp = '{8'hC2, 8'hC3, 8'hC4};
    ext_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ext_tx_valid !== 1'b1 || ext_tx_data !== exp[i]) begin n_fail++; $display("FAIL pp_3q[%0d]: got v=%b d=%h expected v=1 d=%h", i, ext_tx_valid, ext_tx_data, exp[i]); end
      tick();
    end
    n_checks++; if (ext_tx_valid !== 1'b0) begin n_fail++; $display("FAIL pp_3q_empty: got %b expected 0", ext_tx_valid); end
    ext_tx_ready = 1'b0;
    cpu_we = 1'b1;
    for (int i = 0; i < 4; i++) begin cpu_wdata = 8'hD1 + 8'(i); tick(); end
    cpu_wdata = 8'hD5; ext_tx_ready = 1'b1;
    tick();
    cpu_we = 1'b0;
    exp = '{8'hD2, 8'hD3, 8'hD4};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ext_tx_valid !== 1'b1 || ext_tx_data !== exp[i]) begin n_fail++; $display("FAIL pp_full[%0d]: got v=%b d=%h expected v=1 d=%h", i, ext_tx_valid, ext_tx_data, exp[i]); end
      tick();
    end
    n_checks++; if (ext_tx_valid !== 1'b0) begin n_fail++; $display("FAIL pp_full_empty: got %b expected 0", ext_tx_valid); end
    idle();
    cpu_addr = 8'hFE; cpu_re = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    cpu_we = 1'b1; cpu_addr = 8'hFF;
    cpu_wdata = 8'h71; tick();
    cpu_wdata = 8'h72; tick();
    cpu_we = 1'b0;
    ext_rx_data = 8'h3C; ext_rx_valid = 1'b1; tick();
    idle();
    #1;
    n_checks++; if (ext_tx_valid !== 1'b1 || ext_rx_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got v=%b rdy=%b expected v=1 rdy=0", ext_tx_valid, ext_rx_ready); end
    #1;
    reset = 1'b0;
    cpu_addr = 8'hFE;
    #1;
    n_checks++; if (ext_tx_valid !== 1'b0 || ext_tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx: got v=%b d=%h expected v=0 d=00", ext_tx_valid, ext_tx_data); end
    n_checks++; if (ext_rx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rx_ready: got %b expected 1", ext_rx_ready); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_status: got %h expected 00", cpu_rdata); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [7:0] exp_rdata;
    bit         exp_valid;
    bit         full_b;
    bit         push;
    bit         pop;
    bit         rx_was_full;
    m_q.delete();
    m_rx_full = 1'b0;
    m_rx_data = 8'h00;
    m_ovf     = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cpu_we       = ($urandom_range(0, 1) == 1);
      cpu_re       = ($urandom_range(0, 1) == 1);
      cpu_wdata    = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    cpu_addr = 8'hFF;
        2:       cpu_addr = 8'hFE;
        default: cpu_addr = 8'($urandom);
      endcase
      ext_tx_ready = ($urandom_range(0, 2) == 0);
      ext_rx_valid = ($urandom_range(0, 1) == 1);
      ext_rx_data  = 8'($urandom);
      #1;
      exp_valid = (m_q.size() != 0);
      full_b    = (m_q.size() == DEPTH);
      if (cpu_addr == 8'hFF)                  exp_rdata = m_rx_full ? m_rx_data : 8'h00;
      else if (cpu_addr == 8'hFE && STATUS_EN) exp_rdata = {5'b0, m_ovf, m_rx_full, full_b};
      else                                     exp_rdata = 8'h00;
      n_checks++; if (ext_tx_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_tx_valid c=%0d: got %b expected %b", c, ext_tx_valid, exp_valid); end
      if (exp_valid) begin
        n_checks++; if (ext_tx_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_tx_data c=%0d: got %h expected %h", c, ext_tx_data, m_q[0]); end
      end
      n_checks++; if (ext_rx_ready !== !m_rx_full) begin n_fail++; $display("FAIL rnd_rx_ready c=%0d: got %b expected %b", c, ext_rx_ready, !m_rx_full); end
      n_checks++; if (cpu_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d addr=%h: got %h expected %h", c, cpu_addr, cpu_rdata, exp_rdata); end
      push = cpu_we && cpu_addr == 8'hFF;
      pop  = exp_valid && ext_tx_ready;
      if (cpu_re && cpu_addr == 8'hFE) m_ovf = 1'b0;
      if (push && full_b)              m_ovf = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (push && !full_b) m_q.push_back(cpu_wdata);
      rx_was_full = m_rx_full;
      if (rx_was_full && cpu_re && cpu_addr == 8'hFF) m_rx_full = 1'b0;
      else if (!rx_was_full && ext_rx_valid) begin
        m_rx_full = 1'b1;
        m_rx_data = ext_rx_data;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_overflow();
    test_rx();
    test_rx_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
